fc_neuron_seq: RTL and testbench
================================

Name: fc_neuron_seq

Overview:
- Time-multiplexed fully-connected neuron.
- Consumes an IN-element activation vector and its matching signed weights, LANES elements per beat, over a valid/ready stream.
- Accumulates the dot product, adds a signed bias, saturates the result, then applies optional ReLU.
- Sits where the fully-combinational per-neuron layers sit today, trading throughput for area when IN is large or weights are not compile-time constants.

Parameters:
- WIDTH, 8, signed bit width of each activation and each weight.
- IN, 128, vector length; must be a multiple of LANES (elaboration error otherwise).
- LANES, 4, multiply lanes per beat; the transaction takes BEATS = IN/LANES beats.
- RELU, 1, 1 = clamp negative results to 0; 0 = pass the signed result through.
- ACC_W, 2*WIDTH+$clog2(IN), accumulator width, bias width and output width (derived; not overridable).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  beat valid
- in_ready  out  1  block can accept a beat
- x  in  LANES x WIDTH (unpacked [0:LANES-1])  signed activations; lane k = element beat*LANES+k
- w  in  LANES x WIDTH (unpacked [0:LANES-1])  signed weights, aligned with x
- bias  in  ACC_W  signed bias; sampled in the cycle the final beat is accepted
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- z  out  ACC_W  result (signed if RELU=0, non-negative if RELU=1)
- busy  out  1  at least one beat of the current vector has been accepted, result not yet consumed

Behaviour:
- Reset (asynchronous, active-high): state=ACC, beat_cnt=0, acc=0, in_ready=1, out_valid=0, z=0, busy=0.
- Beat accepted when in_valid && in_ready.
- Per accepted beat: acc <= acc + sum over k of sext(x[k])*sext(w[k]). Products are full 2*WIDTH signed; the lane sum is ACC_W wide; beat_cnt increments.
- FSM states:
  - ACC: in_ready=1, out_valid=0. When the accepted beat has beat_cnt==BEATS-1: compute final = acc + lane_sum + bias at ACC_W+1 bits, beat_cnt <= 0, go to HOLD.
  - HOLD: in_ready=0, out_valid=1, z registered. When out_ready: acc <= 0, go to ACC.
- Saturation: final is clamped to the signed ACC_W range. If RELU=1, ReLU is applied after saturation.
- Latency: out_valid rises the cycle after the final beat is accepted.
- Throughput: one beat per cycle; BEATS+1 cycles per vector with no backpressure.
- z and out_valid are stable while out_valid && !out_ready. No new beats are accepted in HOLD; upstream stalls.
- Output and input are never simultaneously live. A beat offered in the same cycle HOLD exits is not accepted; in_ready rises the following cycle.
- in_valid low mid-vector: acc and beat_cnt hold, no timeout.
- Reset mid-vector or during HOLD: partial sum discarded, outputs return to reset values, the next accepted beat is element 0.
- X/W values on non-accepted cycles are ignored.

Decomposition:
- Package fc_pkg holds:
  - state typedef (ACC, HOLD)
  - function acc_width(width, in)
  - saturate/relu helper functions shared with the combinational layers
- Sub-module fc_lane_dot: combinational LANES-wide signed multiply plus balanced adder tree. Output is ACC_W, parameters WIDTH, LANES, ACC_W. Instantiated once.
- FSM, counter, accumulator and output register live in fc_neuron_seq.

Test Plan (WIDTH=8, IN=8, LANES=2, so BEATS=4, ACC_W=19):
- All x=1, w=3, bias=-4, RELU=1, out_ready=1 -> after 4 beats, out_valid high in cycle 5, z=20, in_ready low for exactly 1 cycle.
- All x=1, w=-3, bias=0 -> RELU=1 gives z=0; RELU=0 build gives z=-24 (19'h7FFE8).
- All x=-128, w=-128, bias=19'sh3FFFF -> raw 393215 saturates to z=19'h3FFFF. Same with w=127, bias=-262144 -> z=0 (RELU=1) / 19'h40000 (RELU=0).
- Backpressure and bubbles:
  - out_ready low 5 cycles -> z and out_valid stable, in_ready stays 0, busy stays 1.
  - in_valid toggling every other cycle during ACC -> same result as the back-to-back case.
- Reset mid-vector: 2 beats of x=5,w=5, assert rst 1 cycle, then 4 beats of x=1,w=1, bias=0 -> z=8.
- Back-to-back vectors with out_ready tied high -> two results 5 cycles apart, each correct, no beat lost or double-counted.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared types and helpers for the fully-connected neuron blocks.
package fc_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Accumulator width that holds IN full-precision products without overflow.
  function automatic int acc_width(input int width, input int in);
    return 2 * width + $clog2(in);
  endfunction

  // Clamp a signed value to the signed range of a w-bit result (w < 64).
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Clamp negative values to zero.
  function automatic logic signed [63:0] relu(input logic signed [63:0] v);
    return v[63] ? 64'sd0 : v;
  endfunction

endpackage

// File: rtl/fc_lane_dot.sv
// Combinational LANES-wide signed multiply followed by a balanced adder tree.
module fc_lane_dot #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int ACC_W = 23
) (
  input  logic signed [WIDTH-1:0] i_x [0:LANES-1],
  input  logic signed [WIDTH-1:0] i_w [0:LANES-1],
  output logic signed [ACC_W-1:0] o_sum
);

  // Tree padded to a power of two; unused leaves are tied to zero.
  localparam int LEAVES = 1 << $clog2(LANES);

  // Heap-ordered tree: node n sums nodes 2n and 2n+1, leaves start at LEAVES.
  logic signed [ACC_W-1:0] w_node [1:2*LEAVES-1];

  for (genvar k = 0; k < LEAVES; k++) begin : g_leaf
    if (k < LANES) begin : g_mul
      logic signed [2*WIDTH-1:0] w_prod;
      assign w_prod = i_x[k] * i_w[k];
      assign w_node[LEAVES+k] = ACC_W'(w_prod);
    end else begin : g_pad
      assign w_node[LEAVES+k] = '0;
    end
  end

  for (genvar n = 1; n < LEAVES; n++) begin : g_add
    assign w_node[n] = w_node[2*n] + w_node[2*n+1];
  end

  assign o_sum = w_node[1];

endmodule

// File: rtl/fc_neuron_seq.sv
// Time-multiplexed fully-connected neuron: streams LANES activation/weight
// pairs per beat, accumulates the dot product, adds bias, saturates, ReLU.
module fc_neuron_seq
  import fc_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int IN    = 128,
  parameter  int LANES = 4,
  parameter  int RELU  = 1,
  localparam int ACC_W = acc_width(WIDTH, IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] x [0:LANES-1],
  input  logic signed [WIDTH-1:0] w [0:LANES-1],
  input  logic signed [ACC_W-1:0] bias,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic        [ACC_W-1:0] z,
  output logic                    busy
);

  localparam int BEATS = IN / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (IN % LANES != 0) begin : g_bad_cfg
    $error("fc_neuron_seq: IN must be a multiple of LANES");
  end

  state_t                  r_state;
  state_t                  w_state_next;
  logic        [CNT_W-1:0] r_beat_cnt;
  logic signed [ACC_W-1:0] r_acc;
  logic        [ACC_W-1:0] r_z;
  logic signed [ACC_W-1:0] w_lane_sum;
  logic signed [ACC_W:0]   w_final;
  logic        [ACC_W-1:0] w_z_next;
  logic                    w_fire;
  logic                    w_last;

  fc_lane_dot #(
    .WIDTH (WIDTH),
    .LANES (LANES),
    .ACC_W (ACC_W)
  ) u_lane_dot (
    .i_x   (x),
    .i_w   (w),
    .o_sum (w_lane_sum)
  );

  assign w_fire = in_valid && in_ready;
  assign w_last = (r_beat_cnt == CNT_W'(BEATS - 1));

  // One extra bit so acc + lane sum + bias cannot wrap before saturation.
  assign w_final  = (ACC_W+1)'(r_acc) + (ACC_W+1)'(w_lane_sum) + (ACC_W+1)'(bias);
  assign w_z_next = ACC_W'((RELU != 0) ? relu(saturate(64'(w_final), ACC_W))
                                       : saturate(64'(w_final), ACC_W));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ACC;
    else     r_state <= w_state_next;
  end

  // Next-state and handshake outputs; input and output sides are never live together.
  // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && w_last) w_state_next = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = ACC;
      end
      default: w_state_next = ACC;
    endcase
  end

  // Beat counter, accumulator and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat_cnt <= '0;
      r_acc      <= '0;
      r_z        <= '0;
    end else begin
      if (w_fire) begin
        r_acc <= r_acc + w_lane_sum;
        if (w_last) begin
          r_beat_cnt <= '0;
          r_z        <= w_z_next;
        end else begin
          r_beat_cnt <= r_beat_cnt + CNT_W'(1);
        end
      end
      if (r_state == HOLD && out_ready) r_acc <= '0;
    end
  end

  assign z    = r_z;
  assign busy = (r_state == HOLD) || (r_beat_cnt != '0);

endmodule

// File: tb/tb_fc_neuron_seq.sv
// Directed bench for fc_neuron_seq: WIDTH=8, IN=8, LANES=2 (4 beats, ACC_W=19),
// with a ReLU instance and a linear instance driven from the same stimulus.
module tb_fc_neuron_seq;

  localparam int WIDTH = 8;
  localparam int IN    = 8;
  localparam int LANES = 2;
  localparam int ACC_W = 19;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] x [0:LANES-1];
  logic signed [WIDTH-1:0] w [0:LANES-1];
  logic signed [ACC_W-1:0] bias;

  logic             in_ready_r, out_valid_r, busy_r;
  logic [ACC_W-1:0] z_r;
  logic             in_ready_l, out_valid_l, busy_l;
  logic [ACC_W-1:0] z_l;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fc_neuron_seq #(.WIDTH(WIDTH), .IN(IN), .LANES(LANES), .RELU(1)) u_relu (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r),
    .x(x), .w(w), .bias(bias), .out_valid(out_valid_r), .out_ready(out_ready),
    .z(z_r), .busy(busy_r)
  );

  fc_neuron_seq #(.WIDTH(WIDTH), .IN(IN), .LANES(LANES), .RELU(0)) u_lin (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l),
    .x(x), .w(w), .bias(bias), .out_valid(out_valid_l), .out_ready(out_ready),
    .z(z_l), .busy(busy_l)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int xv, input int wv);
    x[0] = WIDTH'(xv);
    x[1] = WIDTH'(xv);
    w[0] = WIDTH'(wv);
    w[1] = WIDTH'(wv);
  endtask

  // Feed one 4-beat vector of constant x/w; optional idle cycle with junk data between beats.
  task automatic run_vec(input int xv, input int wv, input int bv, input bit gap);
    int   beats = 0;
    int   cyc   = 0;
    logic rdy;
    bias      = ACC_W'(bv);
    out_ready = 1'b0;
    while (beats < 4 && cyc < 40) begin
      in_valid = 1'b1;
      drive(xv, wv);
      rdy = in_ready_r;
      tick();
      cyc++;
      if (rdy) beats++;
      if (gap && beats < 4) begin
        in_valid = 1'b0;
        drive(85, 85);
        tick();
        cyc++;
      end
    end
    in_valid = 1'b0;
    check("beats_accepted", 64'(beats), 64'd4);
    check("out_valid_after_last_beat", 64'(out_valid_r), 64'd1);
    check("lin_out_valid_after_last_beat", 64'(out_valid_l), 64'd1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("consume_out_valid", 64'(out_valid_r), 64'd0);
    check("consume_in_ready", 64'(in_ready_r), 64'd1);
  endtask

  initial begin
    int   bi;
    int   nres;
    int   rc [2];
    logic [ACC_W-1:0] rz [2];
    logic [ACC_W-1:0] rl [2];
    logic rdy;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    bias      = '0;
    drive(0, 0);
    #1;
    check("rst_in_ready", 64'(in_ready_r), 64'd1);
    check("rst_out_valid", 64'(out_valid_r), 64'd0);
    check("rst_z", 64'(z_r), 64'd0);
    check("rst_busy", 64'(busy_r), 64'd0);
    tick();
    tick();
    rst = 1'b0;

    // Test 1: x=1, w=3, bias=-4, out_ready high -> z=20 after 4 beats, in_ready low 1 cycle.
    out_ready = 1'b1;
    bias      = -19'sd4;
    drive(1, 3);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      tick();
      check("t1_out_valid_timing", 64'(out_valid_r), (i == 3) ? 64'd1 : 64'd0);
    end
    in_valid = 1'b0;
    check("t1_z_relu", 64'(z_r), 64'd20);
    check("t1_z_lin", 64'(z_l), 64'd20);
    check("t1_in_ready_low", 64'(in_ready_r), 64'd0);
    check("t1_busy_hold", 64'(busy_r), 64'd1);
    tick();
    check("t1_in_ready_back", 64'(in_ready_r), 64'd1);
    check("t1_out_valid_drop", 64'(out_valid_r), 64'd0);
    check("t1_busy_idle", 64'(busy_r), 64'd0);
    out_ready = 1'b0;

    // Test 3a: positive saturation, with 5 cycles of backpressure and beats offered in HOLD.
    run_vec(-128, -128, 262143, 1'b0);
    check("t3a_z_relu", 64'(z_r), 64'h3FFFF);
    check("t3a_z_lin", 64'(z_l), 64'h3FFFF);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      drive(7, 7);
      tick();
      check("bp_z_stable", 64'(z_r), 64'h3FFFF);
      check("bp_out_valid", 64'(out_valid_r), 64'd1);
      check("bp_in_ready", 64'(in_ready_r), 64'd0);
      check("bp_busy", 64'(busy_r), 64'd1);
    end
    consume();
    in_valid = 1'b0;

    // Test 2: negative result; also shows no beat slipped in while HOLD exited.
    run_vec(1, -3, 0, 1'b0);
    check("t2_z_relu", 64'(z_r), 64'd0);
    check("t2_z_lin", 64'(z_l), 64'h7FFE8);
    consume();

    // Test 3b: negative saturation.
    run_vec(-128, 127, -262144, 1'b0);
    check("t3b_z_relu", 64'(z_r), 64'd0);
    check("t3b_z_lin", 64'(z_l), 64'h40000);
    consume();

    // Bubbles: in_valid toggling gives the same result as test 1.
    run_vec(1, 3, -4, 1'b1);
    check("gap_z_relu", 64'(z_r), 64'd20);
    check("gap_z_lin", 64'(z_l), 64'd20);
    consume();

    // Reset mid-vector: two beats of 5*5, then reset, then 4 beats of 1*1 -> 8.
    bias     = '0;
    in_valid = 1'b1;
    drive(5, 5);
    tick();
    tick();
    in_valid = 1'b0;
    check("mid_busy", 64'(busy_r), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 64'(busy_r), 64'd0);
    check("mid_rst_z", 64'(z_r), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready_r), 64'd1);
    check("mid_rst_out_valid", 64'(out_valid_r), 64'd0);
    tick();
    rst = 1'b0;
    run_vec(1, 1, 0, 1'b0);
    check("mid_z_relu", 64'(z_r), 64'd8);
    check("mid_z_lin", 64'(z_l), 64'd8);
    consume();

    // Back-to-back: vec A (1,3,-4)->20, vec B (2,-1,0)->0 relu / -16 linear; 5 cycles apart.
    bi        = 0;
    nres      = 0;
    rc        = '{0, 0};
    rz        = '{'0, '0};
    rl        = '{'0, '0};
    out_ready = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      in_valid = (bi < 8);
      if (bi < 4) begin
        drive(1, 3);
        bias = -19'sd4;
      end else begin
        drive(2, -1);
        bias = '0;
      end
      rdy = in_ready_r;
      tick();
      if (rdy && in_valid) bi++;
      if (out_valid_r && nres < 2) begin
        rz[nres] = z_r;
        rl[nres] = z_l;
        rc[nres] = cyc;
        nres++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_beats", 64'(bi), 64'd8);
    check("b2b_results", 64'(nres), 64'd2);
    check("b2b_spacing", 64'(rc[1] - rc[0]), 64'd5);
    check("b2b_a_relu", 64'(rz[0]), 64'd20);
    check("b2b_a_lin", 64'(rl[0]), 64'd20);
    check("b2b_b_relu", 64'(rz[1]), 64'd0);
    check("b2b_b_lin", 64'(rl[1]), 64'h7FFF0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
